// File: rtl/zone_alarm_scanner.sv
// Debounces four round-robin-scanned zone sensors and runs the arm/entry/alarm state machine.
// Latency: trip on the DEBOUNCE_SCANS-th consecutive visit; STATE reacts one edge later, ALARM_OUT one edge after that.
// No backpressure: every input is sampled every clock. The door chime is built only with ZONE_CHIME_EN.
module zone_alarm_scanner #(
    parameter int DEBOUNCE_SCANS    = 3,
    parameter int ENTRY_DELAY_SCANS = 8
) (
    input  logic       CLK_IN,
    input  logic       CLR_FF,
    input  logic       D0,
    input  logic       D1,
    input  logic       TC,
    input  logic [3:0] SENSOR,
    input  logic       ARM,
    input  logic       DISARM,
    output logic [1:0] STATE,
    output logic       ALARM_OUT,
    output logic [3:0] ZONE_LATCH,
    output logic       CHIME
);

    typedef enum logic [1:0] {
        ST_DISARMED = 2'b00,
        ST_ARMED    = 2'b01,
        ST_ENTRY    = 2'b10,
        ST_ALARM    = 2'b11
    } state_e;

    localparam logic [2:0] DEB_MAX    = 3'(DEBOUNCE_SCANS);
    localparam logic [3:0] DELAY_LOAD = 4'(ENTRY_DELAY_SCANS);

    logic [1:0] zone;
    logic [2:0] hit_q [4];
    logic [2:0] hit_d [4];
    logic [3:0] trip;

    state_e     state_q;
    logic [3:0] delay_q;
    logic [3:0] zone_latch_q;
    logic       alarm_out_q;

    assign zone = {D1, D0};

    // Only the zone currently addressed by the counter moves; the rest hold.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            hit_d[i] = hit_q[i];
            if (zone == 2'(i)) begin
                if (SENSOR[i]) begin
                    if (hit_q[i] < DEB_MAX) begin
                        hit_d[i] = hit_q[i] + 3'd1;
                    end
                end else begin
                    hit_d[i] = 3'd0;
                end
            end
            trip[i] = (hit_q[i] == DEB_MAX);
        end
    end

    always_ff @(posedge CLK_IN or negedge CLR_FF) begin
        if (!CLR_FF) begin
            for (int i = 0; i < 4; i++) begin
                hit_q[i] <= 3'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                hit_q[i] <= hit_d[i];
            end
        end
    end

    // DISARM is checked first in every state so it always wins.
    always_ff @(posedge CLK_IN or negedge CLR_FF) begin
        if (!CLR_FF) begin
            state_q      <= ST_DISARMED;
            delay_q      <= 4'd0;
            zone_latch_q <= 4'd0;
            alarm_out_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_DISARMED: begin
                    alarm_out_q  <= 1'b0;
                    zone_latch_q <= 4'd0;
                    if (ARM && !DISARM && (trip == 4'd0)) begin
                        state_q <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    alarm_out_q <= 1'b0;
                    if (DISARM) begin
                        state_q      <= ST_DISARMED;
                        zone_latch_q <= 4'd0;
                    end else begin
                        zone_latch_q <= zone_latch_q | trip;
                        if (|trip[3:1]) begin
                            state_q <= ST_ALARM;
                        end else if (trip[0]) begin
                            state_q <= ST_ENTRY;
                            delay_q <= DELAY_LOAD;
                        end
                    end
                end
                ST_ENTRY: begin
                    alarm_out_q <= 1'b0;
                    if (DISARM) begin
                        state_q      <= ST_DISARMED;
                        zone_latch_q <= 4'd0;
                    end else begin
                        zone_latch_q <= zone_latch_q | trip;
                        if (|trip[3:1]) begin
                            state_q <= ST_ALARM;
                        end else if (TC) begin
                            delay_q <= delay_q - 4'd1;
                            if (delay_q <= 4'd1) begin
                                state_q <= ST_ALARM;
                            end
                        end
                    end
                end
                ST_ALARM: begin
                    if (DISARM) begin
                        state_q      <= ST_DISARMED;
                        zone_latch_q <= 4'd0;
                        alarm_out_q  <= 1'b0;
                    end else begin
                        zone_latch_q <= zone_latch_q | trip;
                        alarm_out_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_DISARMED;
                end
            endcase
        end
    end

    assign STATE      = state_q;
    assign ALARM_OUT  = alarm_out_q;
    assign ZONE_LATCH = zone_latch_q;

`ifdef ZONE_CHIME_EN
    logic trip0_q;
    logic chime_q;

    // While trip[0] is high arming is refused, so the FSM cannot leave DISARMED under a chime.
    always_ff @(posedge CLK_IN or negedge CLR_FF) begin
        if (!CLR_FF) begin
            trip0_q <= 1'b0;
            chime_q <= 1'b0;
        end else begin
            trip0_q <= trip[0];
            chime_q <= (state_q == ST_DISARMED) && trip[0] && !trip0_q;
        end
    end

    assign CHIME = chime_q;
`else
    assign CHIME = 1'b0;
`endif

endmodule

// File: tb/tb_zone_alarm_scanner.sv
// Directed scenarios plus randomized sensors, checked every clock against a behavioural model.
module tb_zone_alarm_scanner;

    localparam int DEB = 3;
    localparam int ED  = 8;

    logic       CLK_IN = 1'b0;
    logic       CLR_FF;
    logic       D0, D1, TC;
    logic [3:0] SENSOR;
    logic       ARM, DISARM;
    logic [1:0] STATE;
    logic       ALARM_OUT;
    logic [3:0] ZONE_LATCH;
    logic       CHIME;

    int total = 0;
    int bad   = 0;

    always #5 CLK_IN = ~CLK_IN;

    zone_alarm_scanner #(.DEBOUNCE_SCANS(DEB), .ENTRY_DELAY_SCANS(ED)) dut (
        .CLK_IN(CLK_IN), .CLR_FF(CLR_FF), .D0(D0), .D1(D1), .TC(TC),
        .SENSOR(SENSOR), .ARM(ARM), .DISARM(DISARM), .STATE(STATE),
        .ALARM_OUT(ALARM_OUT), .ZONE_LATCH(ZONE_LATCH), .CHIME(CHIME)
    );

    // Behavioural model: states 0 disarmed, 1 armed, 2 entry, 3 alarm.
    int         cnt;
    int         m_hit [4];
    int         m_state;
    int         m_delay;
    logic [3:0] m_latch;
    bit         m_trip0_prev;
    bit         m_chime;
    bit         m_alarm;

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_hit[i] = 0;
        m_state = 0; m_delay = 0; m_latch = 4'd0;
        m_trip0_prev = 1'b0; m_chime = 1'b0; m_alarm = 1'b0;
    endfunction

    function automatic void model_step();
        int z;
        int ns;
        logic [3:0] tr;
        z = cnt % 4;
        for (int i = 0; i < 4; i++) tr[i] = (m_hit[i] == DEB);
        ns = m_state;
        if (DISARM) begin
            ns = 0;
        end else if (m_state == 0) begin
            if (ARM && tr == 4'd0) ns = 1;
        end else if (m_state == 1 || m_state == 2) begin
            if (tr[3:1] != 3'd0) begin
                ns = 3;
            end else if (m_state == 1 && tr[0]) begin
                ns = 2; m_delay = ED;
            end else if (m_state == 2 && TC) begin
                m_delay = m_delay - 1;
                if (m_delay == 0) ns = 3;
            end
        end
        if (ns == 0) m_latch = 4'd0;
        else if (m_state != 0) m_latch = m_latch | tr;
        m_chime = (m_state == 0) && (ns == 0) && tr[0] && !m_trip0_prev;
`ifndef ZONE_CHIME_EN
        m_chime = 1'b0;
`endif
        m_trip0_prev = tr[0];
        m_alarm = (m_state == 3) && (ns == 3);
        if (SENSOR[z]) m_hit[z] = (m_hit[z] >= DEB) ? DEB : m_hit[z] + 1;
        else m_hit[z] = 0;
        m_state = ns;
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".state"}, {2'b00, STATE}, 4'(m_state));
        chk({tag, ".alarm"}, {3'b000, ALARM_OUT}, {3'b000, m_alarm});
        chk({tag, ".latch"}, ZONE_LATCH, m_latch);
        chk({tag, ".chime"}, {3'b000, CHIME}, {3'b000, m_chime});
    endtask

    task automatic tick(input string tag);
        D1 = cnt[1]; D0 = cnt[0]; TC = (cnt == 3);
        model_step();
        @(posedge CLK_IN); #1;
        cnt = (cnt + 1) % 4;
        check_model(tag);
    endtask

    task automatic do_reset(input string tag);
        #2 CLR_FF = 1'b0;
        #1;
        chk({tag, ".rst_state"}, {2'b00, STATE}, 4'd0);
        chk({tag, ".rst_alarm"}, {3'b000, ALARM_OUT}, 4'd0);
        chk({tag, ".rst_latch"}, ZONE_LATCH, 4'd0);
        chk({tag, ".rst_chime"}, {3'b000, CHIME}, 4'd0);
        model_reset();
        @(posedge CLK_IN); #1;
        CLR_FF = 1'b1;
    endtask

    task automatic pulse_arm(input string tag);
        ARM = 1'b1; tick(tag); ARM = 1'b0;
    endtask

    task automatic pulse_disarm(input string tag);
        DISARM = 1'b1; tick(tag); DISARM = 1'b0;
    endtask

    task automatic clear_zones(input string tag);
        SENSOR = 4'd0;
        for (int i = 0; i < 8; i++) tick(tag);
    endtask

    task automatic wait_state(input string tag, input int target, input int maxn);
        for (int n = 0; n < maxn && m_state != target; n++) tick(tag);
        chk({tag, ".reached"}, {2'b00, STATE}, 4'(target));
    endtask

    initial begin
        int tcs;
        int chimes;
        CLR_FF = 1'b0; ARM = 1'b0; DISARM = 1'b0; SENSOR = 4'd0;
        D0 = 1'b0; D1 = 1'b0; TC = 1'b0; cnt = 0;
        model_reset();
        #12;
        chk("por_state", {2'b00, STATE}, 4'd0);
        chk("por_latch", ZONE_LATCH, 4'd0);
        @(posedge CLK_IN); #1;
        CLR_FF = 1'b1;

        // Reset mid-scan with all sensors active, then watch the debounce ramp.
        SENSOR = 4'b1111;
        for (int i = 0; i < 6; i++) tick("pre_rst");
        do_reset("midscan");
        for (int i = 0; i < 12; i++) tick("post_rst");
        clear_zones("clr1");

        // Arm, then perimeter breach on zone 2.
        pulse_arm("arm1");
        chk("armed1", {2'b00, STATE}, 4'd1);
        SENSOR = 4'b0100;
        wait_state("breach", 3, 20);
        chk("breach_latch", ZONE_LATCH, 4'b0100);
        chk("breach_alarm_lag", {3'b000, ALARM_OUT}, 4'd0);
        tick("breach_next");
        chk("breach_alarm", {3'b000, ALARM_OUT}, 4'd1);

        // Entry delay expiry.
        pulse_disarm("dis1");
        clear_zones("clr2");
        pulse_arm("arm2");
        SENSOR = 4'b0001;
        wait_state("entry", 2, 20);
        wait_state("expiry", 3, 4 * ED + 8);
        chk("expiry_latch", ZONE_LATCH, 4'b0001);

        // Entry, then disarm after five scans.
        pulse_disarm("dis2");
        clear_zones("clr3");
        pulse_arm("arm3");
        SENSOR = 4'b0001;
        wait_state("entry2", 2, 20);
        tcs = 0;
        for (int n = 0; n < 40 && tcs < 5; n++) begin
            if (cnt == 3) tcs++;
            tick("entry2_wait");
        end
        chk("entry2_tcs", 4'(tcs), 4'd5);
        chk("entry2_still", {2'b00, STATE}, 4'd2);
        pulse_disarm("dis3");
        chk("dis3_state", {2'b00, STATE}, 4'd0);
        chk("dis3_latch", ZONE_LATCH, 4'd0);
        chk("dis3_alarm", {3'b000, ALARM_OUT}, 4'd0);

        // Arming refused while a zone is tripped; ARM+DISARM together.
        SENSOR = 4'b0010;
        for (int i = 0; i < 16; i++) tick("hold1");
        pulse_arm("refused");
        chk("refused_state", {2'b00, STATE}, 4'd0);
        clear_zones("clr4");
        pulse_arm("arm4");
        chk("arm4_state", {2'b00, STATE}, 4'd1);
        ARM = 1'b1; DISARM = 1'b1;
        tick("both");
        ARM = 1'b0; DISARM = 1'b0;
        chk("both_state", {2'b00, STATE}, 4'd0);

        // Two-visit glitch on zone 3 while armed.
        pulse_arm("arm5");
        for (int n = 0; n < 4 && cnt != 0; n++) tick("align");
        SENSOR = 4'b1000;
        for (int i = 0; i < 8; i++) tick("glitch");
        SENSOR = 4'b0000;
        for (int i = 0; i < 8; i++) tick("glitch_off");
        chk("glitch_state", {2'b00, STATE}, 4'd1);
        chk("glitch_latch", ZONE_LATCH, 4'd0);

        // Door chime while disarmed.
        pulse_disarm("dis5");
        SENSOR = 4'b0001;
        chimes = 0;
        for (int i = 0; i < 16; i++) begin
            tick("chime");
            if (CHIME === 1'b1) chimes++;
        end
`ifdef ZONE_CHIME_EN
        chk("chime_count", 4'(chimes), 4'd1);
`else
        chk("chime_count", 4'(chimes), 4'd0);
`endif
        clear_zones("clr5");

        // Randomized sensors and controls.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) SENSOR = 4'($urandom_range(0, 15));
            ARM = ($urandom_range(0, 15) == 0);
            DISARM = ($urandom_range(0, 60) == 0);
            tick("rand");
            if (i == 1500) do_reset("rand_rst");
        end
        ARM = 1'b0; DISARM = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
